// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - memory bus bundle between the access unit (master) and memory (slave)
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - fetch/load/store bus access sequencer with instr and mdr capture
// Optional ack timeout abort enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         pc,
  input  logic [31:0]         alu_out,
  input  logic [31:0]         write_data,
  input  logic                iord,
  input  logic                ir_write,
  input  logic                mem_read,
  input  logic                mem_write,
  mem_access_unit_if.master   bus,
  output logic [31:0]         instr,
  output logic [5:0]          opcode,
  output logic [5:0]          funct,
  output logic [31:0]         mdr,
  output logic                stall,
  output logic                done,
  output logic                bus_err
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_access_unit: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [1:0] KIND_FETCH = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;

  state_t      state, state_nx;
  logic [1:0]  kind_q;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic        any_req, multi_req, accept, timeout_hit;

  assign any_req   = ir_write | mem_read | mem_write;
  assign multi_req = (ir_write & (mem_read | mem_write)) | (mem_read & mem_write);
  assign accept    = (state == IDLE) && any_req;

`ifdef MAU_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (state == REQ) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  // wait_cnt equals the number of REQ cycles already completed
  assign timeout_hit = (state == REQ) && !bus.bus_ack && (wait_cnt == 8'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = REQ;
      REQ:     if (bus.bus_ack || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q  <= KIND_FETCH;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      instr   <= 32'd0;
      mdr     <= 32'd0;
      bus_err <= 1'b0;
    end else begin
      if (accept) begin
        kind_q  <= ir_write ? KIND_FETCH : (mem_read ? KIND_LOAD : KIND_STORE);
        addr_q  <= iord ? alu_out : pc;
        we_q    <= !ir_write && !mem_read;
        wdata_q <= (!ir_write && !mem_read) ? write_data : 32'd0;
        if (multi_req) bus_err <= 1'b1;
      end
      if (state == REQ && bus.bus_ack) begin
        if (kind_q == KIND_FETCH) instr <= bus.bus_rdata;
        if (kind_q == KIND_LOAD)  mdr   <= bus.bus_rdata;
      end
      if (timeout_hit) bus_err <= 1'b1;
    end
  end

  always_comb begin
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 32'd0;
    bus.bus_wdata = 32'd0;
    done          = 1'b0;
    stall         = 1'b0;
    case (state)
      IDLE: stall = any_req;
      REQ: begin
        bus.bus_req   = 1'b1;
        bus.bus_we    = we_q;
        bus.bus_addr  = addr_q;
        bus.bus_wdata = wdata_q;
        stall         = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;
`ifdef MAU_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, alu_out, write_data;
  logic        iord, ir_write, mem_read, mem_write;
  logic [31:0] instr, mdr;
  logic [5:0]  opcode, funct;
  logic        stall, done, bus_err;

  mem_access_unit_if bif ();

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .alu_out(alu_out), .write_data(write_data),
    .iord(iord), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .bus(bif), .instr(instr), .opcode(opcode), .funct(funct), .mdr(mdr),
    .stall(stall), .done(done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_mdr = 32'd0;
  logic        m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push_model();
    exp_t e;
    e.instr = m_instr;
    e.mdr   = m_mdr;
    e.err   = m_err;
    sb.push_back(e);
  endtask

  // Completion monitor: every done pulse retires one scoreboard entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr", instr, e.instr);
        check("sb_mdr", mdr, e.mdr);
        check("sb_bus_err", {31'd0, bus_err}, {31'd0, e.err});
        check("sb_opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
        check("sb_funct", {26'd0, funct}, {26'd0, e.instr[5:0]});
      end
    end
  end

  task automatic access(input bit ir, input bit mr, input bit mw, input bit sel,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] wd,
                        input int delay, input logic [31:0] rd);
    logic [31:0] exp_addr, exp_wdata;
    bit          is_store;
    @(negedge clk);
    ir_write = ir; mem_read = mr; mem_write = mw;
    iord = sel; pc = p; alu_out = a; write_data = wd;
    #1 check("stall_idle_req", {31'd0, stall}, 32'd1);
    is_store  = !ir && !mr && mw;
    exp_addr  = sel ? a : p;
    exp_wdata = is_store ? wd : 32'd0;
    if (ir) m_instr = rd;
    else if (mr) m_mdr = rd;
    if (int'(ir) + int'(mr) + int'(mw) > 1) m_err = 1'b1;
    push_model();
    @(negedge clk);
    ir_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    pc = $urandom; alu_out = $urandom; write_data = $urandom;
    for (int i = 0; i <= delay; i++) begin
      check("req_bus_req", {31'd0, bif.bus_req}, 32'd1);
      check("req_bus_addr", bif.bus_addr, exp_addr);
      check("req_bus_we", {31'd0, bif.bus_we}, {31'd0, is_store});
      check("req_bus_wdata", bif.bus_wdata, exp_wdata);
      check("req_stall", {31'd0, stall}, 32'd1);
      check("req_done", {31'd0, done}, 32'd0);
      if (i < delay) @(negedge clk);
    end
    bif.bus_ack = 1'b1; bif.bus_rdata = rd;
    @(negedge clk);
    bif.bus_ack = 1'b0; bif.bus_rdata = $urandom;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_stall", {31'd0, stall}, 32'd0);
    check("done_bus_req", {31'd0, bif.bus_req}, 32'd0);
    check("done_bus_addr", bif.bus_addr, 32'd0);
    @(negedge clk);
    check("idle_done_low", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    pc = 32'd0; alu_out = 32'd0; write_data = 32'd0;
    iord = 1'b0; ir_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", {31'd0, bif.bus_req}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_mdr", mdr, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    access(1, 0, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 3, 32'h8C82_0004);
    access(0, 1, 0, 1, 32'h0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    access(0, 0, 1, 1, 32'h0, 32'h0000_0200, 32'h1234_5678, 2, 32'h5555_AAAA);
    access(1, 0, 0, 1, 32'h0, 32'h0000_0300, 32'h0, 1, 32'h0000_002A);
    access(0, 0, 1, 0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 0, 32'h0BAD_0BAD);

    // Stray ack while idle must not capture anything
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    check("idle_ack_done", {31'd0, done}, 32'd0);
    check("idle_ack_instr", instr, m_instr);
    check("idle_ack_mdr", mdr, m_mdr);
    check("idle_ack_err", {31'd0, bus_err}, 32'd0);

    access(1, 0, 1, 0, 32'h0000_0048, 32'h0, 32'h7777_7777, 1, 32'h2108_0020);
    check("multi_err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset in the middle of a pending load
    @(negedge clk);
    mem_read = 1'b1; iord = 1'b1; alu_out = 32'h0000_0400;
    @(negedge clk);
    mem_read = 1'b0;
    check("rstmid_bus_req_pre", {31'd0, bif.bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    m_instr = 32'd0; m_mdr = 32'd0; m_err = 1'b0;
    check("rstmid_bus_req", {31'd0, bif.bus_req}, 32'd0);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    check("rstmid_instr", instr, 32'd0);
    check("rstmid_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    check("late_ack_done", {31'd0, done}, 32'd0);
    check("late_ack_mdr", mdr, 32'd0);
    check("late_ack_bus_req", {31'd0, bif.bus_req}, 32'd0);

`ifdef MAU_TIMEOUT_EN
    access(1, 0, 0, 0, 32'h0000_0050, 32'h0, 32'h0, 0, 32'h0000_0011);
    @(negedge clk);
    ir_write = 1'b1; iord = 1'b0; pc = 32'h0000_0080;
    m_err = 1'b1;
    push_model();
    @(negedge clk);
    ir_write = 1'b0;
    cnt = 0;
    while (bif.bus_req === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_req_cycles", cnt, TMO);
    check("timeout_done", {31'd0, done}, 32'd1);
    check("timeout_err", {31'd0, bus_err}, 32'd1);
    @(negedge clk);
`else
    cnt = 0;
`endif

    @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles waited for bus_ack before abort (1..255).
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 pc  in  32  fetch address source.
REQ-005 alu_out  in  32  data-access address source.
REQ-006 write_data  in  32  store data (register B value).
REQ-007 iord  in  1  address select: 0 = pc, 1 = alu_out.
REQ-008 ir_write  in  1  instruction fetch request from control unit.
REQ-009 mem_read  in  1  data load request.
REQ-010 mem_write  in  1  data store request.
REQ-011 bus_req  out  1  memory bus request.
REQ-012 bus_we  out  1  bus write enable.
REQ-013 bus_addr  out  32  bus address.
REQ-014 bus_wdata  out  32  bus write data.
REQ-015 bus_ack  in  1  bus completion, one-cycle pulse.
REQ-016 bus_rdata  in  32  bus read data, valid with bus_ack.
REQ-017 instr  out  32  instruction register.
REQ-018 opcode  out  6  instr[31:26], feeds control unit.
REQ-019 funct  out  6  instr[5:0], feeds control unit.
REQ-020 mdr  out  32  memory data register.
REQ-021 stall  out  1  freeze request to control unit and PC.
REQ-022 done  out  1  one-cycle access-complete pulse.
REQ-023 bus_err  out  1  sticky protocol/timeout error flag.

Function
REQ-024 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-025 Request sampled only in IDLE: any of ir_write, mem_read, mem_write high at a rising edge -> REQ; requests in REQ/DONE ignored.
REQ-026 At acceptance: latch kind (fetch/load/store), bus_addr = iord ? alu_out : pc, bus_wdata = write_data (store only), bus_we = 1 for store.
REQ-027 Priority: ir_write > mem_read > mem_write; more than one high -> highest served, bus_err set.
REQ-028 bus_req, bus_addr, bus_we, bus_wdata held stable throughout REQ; all low/zero outside REQ.
REQ-029 REQ + bus_ack: capture bus_rdata into instr (fetch) or mdr (load), none for store; -> DONE same edge.
REQ-030 DONE lasts exactly one cycle, done = 1, then IDLE; minimum latency acceptance-to-done = 2 cycles.
REQ-031 stall = 1 combinationally in IDLE when any request input high, and throughout REQ; 0 in DONE.
REQ-032 bus_ack in IDLE or DONE ignored; no capture; no error.
REQ-033 instr and mdr hold values until next capture of their kind.
REQ-034 bus_err cleared only by reset.

Reset
REQ-035 rst_n low, asynchronously: state IDLE; bus_req, bus_we, done, bus_err = 0; bus_addr, bus_wdata, instr, mdr = 0; wait counter = 0.
REQ-036 Reset during REQ drops bus_req immediately; the pending access is discarded, no capture.

Configuration
REQ-037 Macro MAU_TIMEOUT_EN defined: 8-bit counter increments each REQ cycle; TIMEOUT cycles without bus_ack -> drop bus_req, set bus_err, -> DONE with no capture.
REQ-038 Macro MAU_TIMEOUT_EN undefined: no counter, REQ waits indefinitely; bus_err set only by REQ-027.

Verification
REQ-039 Fetch: pc=0x00000040, iord=0, ir_write=1, ack 3 cycles later with rdata=0x8C820004 -> bus_addr 0x40, instr=0x8C820004, opcode=0x23, done 1 cycle, stall low in DONE.
REQ-040 Load: iord=1, alu_out=0x100, mem_read=1, ack rdata=0xDEADBEEF -> mdr=0xDEADBEEF, instr unchanged.
REQ-041 Store: alu_out=0x200, write_data=0x12345678, mem_write=1 -> bus_we=1, bus_wdata=0x12345678 stable until ack, mdr unchanged.
REQ-042 ir_write=1 and mem_write=1 together -> fetch served, bus_we=0, bus_err=1.
REQ-043 MAU_TIMEOUT_EN, TIMEOUT=4, no ack -> bus_req falls after 4 REQ cycles, bus_err=1, done pulse, instr unchanged.
REQ-044 rst_n low mid-REQ -> bus_req 0 before next edge, state IDLE, late bus_ack ignored.
